// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and widths for the DMEM arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int DMEM_ADDR_W = 11;
    localparam int DMEM_DATA_W = 32;

    // IDLE: no owner; OWN0/OWN1: requester holds a lock on the DMEM port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Two-way priority pick. When both request, ptr selects the
//               winner; a lone requester always wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic gnt0,
    output logic gnt1
);

    // At most one grant; ptr breaks the tie.
    always_comb begin
        gnt0 = req0 & (~req1 | ~ptr);
        gnt1 = req1 & (~req0 |  ptr);
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin arbiter with bounded ownership lock in front of a
//               single-port DMEM. Read data is registered and returned one
//               cycle after the grant.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ena,
    output logic              mem_wena,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    arb_state_t        state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              w_hold_full;
    logic              w_pick_ptr;
    logic              w_gnt0;
    logic              w_gnt1;

    assign w_hold_full = (hold_cnt_q == HOLD_MAX);

    // Effective tie-break pointer: an owner keeps priority until the other
    // side has waited MAX_HOLD locked re-grants, then priority flips to it.
    // A dropped owner request falls through to the other side naturally.
    always_comb begin
        w_pick_ptr = rr_ptr_q;
        case (state_q)
            OWN0:    w_pick_ptr = (req1 && w_hold_full) ? 1'b1 : 1'b0;
            OWN1:    w_pick_ptr = (req0 && w_hold_full) ? 1'b0 : 1'b1;
            default: w_pick_ptr = rr_ptr_q;
        endcase
    end

    rr_pick2 u_pick (
        .req0 (req0),
        .req1 (req1),
        .ptr  (w_pick_ptr),
        .gnt0 (w_gnt0),
        .gnt1 (w_gnt1)
    );

    assign gnt0 = w_gnt0;
    assign gnt1 = w_gnt1;

    // DMEM command mux; bus is zeroed when nobody is granted.
    always_comb begin
        mem_ena   = 1'b0;
        mem_wena  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_gnt0) begin
            mem_ena   = 1'b1;
            mem_wena  = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (w_gnt1) begin
            mem_ena   = 1'b1;
            mem_wena  = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    // Next ownership state, round-robin pointer and hold counter. The counter
    // only advances on a locked re-grant to the same owner while the other
    // side waits; taking fresh ownership starts it from zero.
    always_comb begin
        state_d    = IDLE;
        hold_cnt_d = '0;
        rr_ptr_d   = rr_ptr_q;
        if (w_gnt0) begin
            rr_ptr_d = 1'b1;
            if (lock0) begin
                state_d = OWN0;
                if (state_q == OWN0 && req1)
                    hold_cnt_d = w_hold_full ? HOLD_MAX : hold_cnt_q + HOLD_ONE;
            end
        end else if (w_gnt1) begin
            rr_ptr_d = 1'b0;
            if (lock1) begin
                state_d = OWN1;
                if (state_q == OWN1 && req0)
                    hold_cnt_d = w_hold_full ? HOLD_MAX : hold_cnt_q + HOLD_ONE;
            end
        end
    end

    // Read return: capture DMEM output on a read grant, flag it for one cycle.
    always_comb begin
        rvalid0_d = w_gnt0 & ~we0;
        rvalid1_d = w_gnt1 & ~we1;
        rdata_d   = (rvalid0_d | rvalid1_d) ? mem_rdata : rdata_q;
    end

    // State registers; reset clears any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 1'b0;
            hold_cnt_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata_q    <= rdata_d;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata   = rdata_q;

endmodule
`default_nettype wire
